// File: rtl/calendar_pkg.sv
// Shared types, constants and the leap-year helper
// for the calendar controller.
package calendar_pkg;

  typedef enum logic [1:0] {
    RUN,
    CHECK,
    COMMIT
  } cal_state_t;

  localparam logic [3:0] MONTH_JAN = 4'd1;
  localparam logic [3:0] MONTH_DEC = 4'd12;
  localparam logic [2:0] DOW_SAT   = 3'd6;

  function automatic logic is_leap(input logic [13:0] y);
    return ((y % 14'd4) == 14'd0) &&
           (((y % 14'd100) != 14'd0) ||
            ((y % 14'd400) == 14'd0));
  endfunction

endpackage

// File: rtl/calendar_numdays.sv
// Days-in-month lookup; returns 0 for months
// outside 1..12.
module numDays (
  input  logic [3:0] month,
  input  logic       leap_year,
  output logic [4:0] days
);

  always_comb begin
    days = 5'd0;
    case (month)
      4'd1, 4'd3, 4'd5, 4'd7,
      4'd8, 4'd10, 4'd12: days = 5'd31;
      4'd4, 4'd6, 4'd9,
      4'd11:              days = 5'd30;
      4'd2:               days = leap_year ? 5'd29 : 5'd28;
      default:            days = 5'd0;
    endcase
  end

endmodule

// File: rtl/calendar_ctrl.sv
// Calendar date sequencer: midnight advance plus
// validated user loads via valid/ready.
module calendar_ctrl
  import calendar_pkg::*;
#(
  parameter logic [13:0] RESET_YEAR  = 14'd2024,
  parameter logic [3:0]  RESET_MONTH = 4'd1,
  parameter logic [4:0]  RESET_DAY   = 5'd1,
  parameter logic [2:0]  RESET_DOW   = 3'd1,
  parameter logic [13:0] YEAR_MAX    = 14'd9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        day_tick,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [13:0] set_year,
  input  logic [3:0]  set_month,
  input  logic [4:0]  set_day,
  input  logic [2:0]  set_dow,
  output logic        set_ok,
  output logic        set_err,
  output logic [13:0] year,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic [2:0]  dow,
  output logic        leap_year,
  output logic        new_month,
  output logic        new_year
);

  cal_state_t  state, state_n;
  logic [13:0] ld_year;
  logic [3:0]  ld_month;
  logic [4:0]  ld_day;
  logic [2:0]  ld_dow;
  logic        ld_ok;
  logic        pending;
  logic [4:0]  dim, ld_dim;
  logic        accept, advance;

  assign leap_year = is_leap(year);
  assign set_ready = (state == RUN);
  assign accept    = set_ready && set_valid;
  // A load in RUN always outranks a due advance.
  assign advance   = set_ready && !set_valid &&
                     (day_tick || pending);

  numDays u_dim_live (
    .month     (month),
    .leap_year (leap_year),
    .days      (dim)
  );

  numDays u_dim_check (
    .month     (ld_month),
    .leap_year (is_leap(ld_year)),
    .days      (ld_dim)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:     if (set_valid) state_n = CHECK;
      CHECK:   state_n = COMMIT;
      COMMIT:  state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      year      <= RESET_YEAR;
      month     <= RESET_MONTH;
      day       <= RESET_DAY;
      dow       <= RESET_DOW;
      ld_year   <= '0;
      ld_month  <= '0;
      ld_day    <= '0;
      ld_dow    <= '0;
      ld_ok     <= 1'b0;
      pending   <= 1'b0;
      set_ok    <= 1'b0;
      set_err   <= 1'b0;
      new_month <= 1'b0;
      new_year  <= 1'b0;
    end else begin
      set_ok    <= 1'b0;
      set_err   <= 1'b0;
      new_month <= 1'b0;
      new_year  <= 1'b0;

      if (accept) begin
        ld_year  <= set_year;
        ld_month <= set_month;
        ld_day   <= set_day;
        ld_dow   <= set_dow;
      end

      if (state == CHECK) begin
        ld_ok <= (ld_month >= MONTH_JAN) &&
                 (ld_month <= MONTH_DEC) &&
                 (ld_day != 5'd0) &&
                 (ld_day <= ld_dim) &&
                 (ld_year <= YEAR_MAX) &&
                 (ld_dow <= DOW_SAT);
      end

      if (state == COMMIT) begin
        if (ld_ok) begin
          year   <= ld_year;
          month  <= ld_month;
          day    <= ld_day;
          dow    <= ld_dow;
          set_ok <= 1'b1;
        end else begin
          set_err <= 1'b1;
        end
      end

      if (advance) begin
        dow <= (dow == DOW_SAT) ? 3'd0 : dow + 3'd1;
        if (day < dim) begin
          day <= day + 5'd1;
        end else begin
          day       <= 5'd1;
          new_month <= 1'b1;
          if (month == MONTH_DEC) begin
            month    <= MONTH_JAN;
            new_year <= 1'b1;
            year     <= (year == YEAR_MAX) ?
                        14'd0 : year + 14'd1;
          end else begin
            month <= month + 4'd1;
          end
        end
      end

      // Ticks that cannot be served now wait one slot.
      if (advance)       pending <= 1'b0;
      else if (day_tick) pending <= 1'b1;
    end
  end

endmodule
